reg_file_seq: RTL

//  Multi-cycle micro-op sequencer for the 8x16 reg_file (2 read ports, 1 write port).

---
 rtl/reg_file_seq_if.sv | 36 +++
 rtl/reg_file_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/reg_file_seq_if.sv
// Sequencer <-> instruction source / reg_file signal bundle; master = sequencer side.
// Flag outputs exist only when RFS_FLAGS_EN is defined.
interface reg_file_seq_if;
  logic        instr_valid;
  logic [0:15] instr;
  logic        instr_ready;
  logic [0:2]  rd_addr_a;
  logic [0:2]  rd_addr_b;
  logic [0:15] d_out_a;
  logic [0:15] d_out_b;
  logic        wr;
  logic [0:2]  wr_addr;
  logic [0:15] d_in;
  logic        busy;
  logic        done;
`ifdef RFS_FLAGS_EN
  logic        flag_z;
  logic        flag_c;
`endif

  modport master (
    input  instr_valid, instr, d_out_a, d_out_b,
    output instr_ready, rd_addr_a, rd_addr_b, wr, wr_addr, d_in, busy, done
`ifdef RFS_FLAGS_EN
    , output flag_z, flag_c
`endif
  );

  modport slave (
    output instr_valid, instr, d_out_a, d_out_b,
    input  instr_ready, rd_addr_a, rd_addr_b, wr, wr_addr, d_in, busy, done
`ifdef RFS_FLAGS_EN
    , input flag_z, flag_c
`endif
  );
endinterface

// File: rtl/reg_file_seq.sv
// Four-state micro-op sequencer (IDLE/READ/EXEC/WRITE) driving an 8x16 reg_file; one instr per 4 cycles.
// Optional zero/carry flag outputs are built when RFS_FLAGS_EN is defined.
module reg_file_seq #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit LDI_SEXT = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_seq_if.master bus
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t            state;
  logic [0:15]       instr_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic              ready_q;

  logic [2:0]        op;
  logic [ADDR_W-1:0] dst;
  logic [9:0]        imm10;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] result;

  assign op      = instr_q[0:2];
  assign dst     = instr_q[3:5];
  assign imm10   = instr_q[6:15];
  assign imm_ext = {{(DATA_W-10){LDI_SEXT & imm10[9]}}, imm10};

  // Gated by reset so the source sees not-ready in the reset cycle and ready right after.
  assign bus.instr_ready = ready_q & ~reset;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = opa_q + opb_q;
      OP_SUB:  result = opa_q - opb_q;
      OP_AND:  result = opa_q & opb_q;
      OP_OR:   result = opa_q | opb_q;
      OP_XOR:  result = opa_q ^ opb_q;
      OP_MOV:  result = opa_q;
      OP_LDI:  result = imm_ext;
      default: result = '0;
    endcase
  end

`ifdef RFS_FLAGS_EN
  logic              flag_upd;
  logic              carry_nxt;
  logic [DATA_W:0]   sum_ext;

  assign sum_ext = {1'b0, opa_q} + {1'b0, opb_q};

  always_comb begin
    flag_upd  = 1'b0;
    carry_nxt = 1'b0;
    case (op)
      OP_ADD: begin flag_upd = 1'b1; carry_nxt = sum_ext[DATA_W]; end
      OP_SUB: begin flag_upd = 1'b1; carry_nxt = (opa_q < opb_q); end
      OP_AND, OP_OR, OP_XOR: flag_upd = 1'b1;
      default: flag_upd = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ready_q       <= 1'b1;
      instr_q       <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.wr        <= 1'b0;
      bus.wr_addr   <= '0;
      bus.d_in      <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
`ifdef RFS_FLAGS_EN
      bus.flag_z    <= 1'b0;
      bus.flag_c    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid && ready_q) begin
            instr_q       <= bus.instr;
            bus.rd_addr_a <= bus.instr[6:8];
            bus.rd_addr_b <= bus.instr[9:11];
            ready_q       <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          // Operands captured here, so dst aliasing a source is harmless.
          opa_q <= bus.d_out_a;
          opb_q <= bus.d_out_b;
          state <= EXEC;
        end
        EXEC: begin
          bus.wr      <= (op != OP_NOP);
          bus.wr_addr <= dst;
          bus.d_in    <= result;
          bus.done    <= 1'b1;
`ifdef RFS_FLAGS_EN
          if (flag_upd) begin
            bus.flag_z <= (result == '0);
            bus.flag_c <= carry_nxt;
          end
`endif
          state <= WRITE;
        end
        WRITE: begin
          bus.wr   <= 1'b0;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          ready_q  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
